// File: rtl/pe_pkg.sv
// Shared constants and helpers for the pipelined parallel PE.
// Control-bit indices, tree width and saturation limits.
package pe_pkg;

    localparam int CTL_FIRST = 0;
    localparam int CTL_LAST  = 1;

    function automatic int tree_w(input int dw, input int lanes);
        return 2 * dw + $clog2(lanes);
    endfunction

    // Limits are produced 64 bits wide and truncated by the user to ACC_W.
    function automatic logic [63:0] sat_max(input int acc_w);
        return (64'd1 << (acc_w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int acc_w);
        return 64'd1 << (acc_w - 1);
    endfunction

endpackage

// File: rtl/pe_adder_tree.sv
// Combinational reduction of LANES products into one sum.
// Each product is sign- or zero-extended before summing.
module pe_adder_tree #(
    parameter int LANES = 32,
    parameter int IN_W  = 32,
    parameter int OUT_W = IN_W + $clog2(LANES)
) (
    input  logic [LANES*IN_W-1:0] prod,
    input  logic                  sgn,
    output logic [OUT_W-1:0]      sum
);

    always_comb begin
        logic [IN_W-1:0] p;
        sum = '0;
        for (int i = 0; i < LANES; i++) begin
            p   = prod[i*IN_W +: IN_W];
            sum = sum + {{(OUT_W-IN_W){p[IN_W-1] & sgn}}, p};
        end
    end

endmodule

// File: rtl/parallel_pe_pipe.sv
// Pipelined LANES-wide dot-product accumulator with valid/ready
// handshakes, signed/unsigned operands and optional saturation.
module parallel_pe_pipe
    import pe_pkg::*;
#(
    parameter int LANES = 32,
    parameter int DW    = 16,
    parameter int ACC_W = 32,
    parameter int SAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [LANES*DW-1:0]   neuron,
    input  logic [LANES*DW-1:0]   weight,
    input  logic [1:0]            ctl,
    input  logic                  sgn,
    input  logic                  vld_i,
    output logic                  rdy_o,
    output logic [ACC_W-1:0]      result,
    output logic                  ovf,
    output logic                  vld_o,
    input  logic                  rdy_i
);

    localparam int PW = 2 * DW;
    localparam int TW = tree_w(DW, LANES);
    localparam int XW = ((ACC_W > TW) ? ACC_W : TW) + 2;
    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(ACC_W));

    logic [LANES*PW-1:0] prod_d, prod_q, prod_in;
    logic                s1_vld_d, s1_vld_q, s1_sgn_d, s1_sgn_q;
    logic [1:0]          s1_ctl_d, s1_ctl_q;
    logic [TW-1:0]       sum_d, sum_q, tree_sum;
    logic                s2_vld_d, s2_vld_q, s2_sgn_d, s2_sgn_q;
    logic [1:0]          s2_ctl_d, s2_ctl_q;
    logic [ACC_W-1:0]    acc_d, acc_q, acc_new;
    logic                ovf_acc_d, ovf_acc_q, ovf_new;
    logic                s3_vld_d, s3_vld_q, s3_last_d, s3_last_q;
    logic [ACC_W-1:0]    res_d, res_q;
    logic                ovf_d, ovf_q, vld_o_d, vld_o_q;
    logic                stall;

    assign stall  = vld_o_q && !rdy_i;
    assign rdy_o  = !stall;
    assign result = res_q;
    assign ovf    = ovf_q;
    assign vld_o  = vld_o_q;

    // Operands are extended to 2*DW so one multiplier serves both modes.
    always_comb begin
        logic [PW-1:0] a, b;
        prod_in = '0;
        for (int i = 0; i < LANES; i++) begin
            a = {{DW{neuron[i*DW+DW-1] & sgn}}, neuron[i*DW +: DW]};
            b = {{DW{weight[i*DW+DW-1] & sgn}}, weight[i*DW +: DW]};
            prod_in[i*PW +: PW] = a * b;
        end
    end

    pe_adder_tree #(
        .LANES (LANES),
        .IN_W  (PW),
        .OUT_W (TW)
    ) u_tree (
        .prod (prod_q),
        .sgn  (s1_sgn_q),
        .sum  (tree_sum)
    );

    always_comb begin
        logic          use_s, first, s_ovf, carry;
        logic [XW-1:0] sum_x, acc_x, base_x, tot_x;
        use_s  = s2_sgn_q || (SAT != 0);
        first  = s2_ctl_q[CTL_FIRST];
        sum_x  = {{(XW-TW){sum_q[TW-1] & s2_sgn_q}}, sum_q};
        acc_x  = {{(XW-ACC_W){acc_q[ACC_W-1] & use_s}}, acc_q};
        base_x = first ? '0 : acc_x;
        tot_x  = base_x + sum_x;
        s_ovf  = !((&tot_x[XW-1:ACC_W-1]) || !(|tot_x[XW-1:ACC_W-1]));
        carry  = |tot_x[XW-1:ACC_W];
        ovf_new = (first ? 1'b0 : ovf_acc_q) | (use_s ? s_ovf : carry);
        if ((SAT != 0) && s_ovf)
            acc_new = tot_x[XW-1] ? SAT_MIN : SAT_MAX;
        else
            acc_new = tot_x[ACC_W-1:0];
    end

    always_comb begin
        prod_d    = prod_q;
        s1_vld_d  = s1_vld_q;
        s1_ctl_d  = s1_ctl_q;
        s1_sgn_d  = s1_sgn_q;
        sum_d     = sum_q;
        s2_vld_d  = s2_vld_q;
        s2_ctl_d  = s2_ctl_q;
        s2_sgn_d  = s2_sgn_q;
        acc_d     = acc_q;
        ovf_acc_d = ovf_acc_q;
        s3_vld_d  = s3_vld_q;
        s3_last_d = s3_last_q;
        res_d     = res_q;
        ovf_d     = ovf_q;
        vld_o_d   = vld_o_q;
        if (!stall) begin
            prod_d    = prod_in;
            s1_vld_d  = vld_i;
            s1_ctl_d  = ctl;
            s1_sgn_d  = sgn;
            sum_d     = tree_sum;
            s2_vld_d  = s1_vld_q;
            s2_ctl_d  = s1_ctl_q;
            s2_sgn_d  = s1_sgn_q;
            s3_vld_d  = s2_vld_q;
            s3_last_d = s2_vld_q && s2_ctl_q[CTL_LAST];
            if (s2_vld_q) begin
                acc_d     = acc_new;
                ovf_acc_d = ovf_new;
            end
            if (s3_vld_q && s3_last_q) begin
                res_d   = acc_q;
                ovf_d   = ovf_acc_q;
                vld_o_d = 1'b1;
            end else begin
                vld_o_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q    <= '0;
            s1_vld_q  <= 1'b0;
            s1_ctl_q  <= '0;
            s1_sgn_q  <= 1'b0;
            sum_q     <= '0;
            s2_vld_q  <= 1'b0;
            s2_ctl_q  <= '0;
            s2_sgn_q  <= 1'b0;
            acc_q     <= '0;
            ovf_acc_q <= 1'b0;
            s3_vld_q  <= 1'b0;
            s3_last_q <= 1'b0;
            res_q     <= '0;
            ovf_q     <= 1'b0;
            vld_o_q   <= 1'b0;
        end else begin
            prod_q    <= prod_d;
            s1_vld_q  <= s1_vld_d;
            s1_ctl_q  <= s1_ctl_d;
            s1_sgn_q  <= s1_sgn_d;
            sum_q     <= sum_d;
            s2_vld_q  <= s2_vld_d;
            s2_ctl_q  <= s2_ctl_d;
            s2_sgn_q  <= s2_sgn_d;
            acc_q     <= acc_d;
            ovf_acc_q <= ovf_acc_d;
            s3_vld_q  <= s3_vld_d;
            s3_last_q <= s3_last_d;
            res_q     <= res_d;
            ovf_q     <= ovf_d;
            vld_o_q   <= vld_o_d;
        end
    end

endmodule
